tm1638_frame_scanner: RTL and testbench

- Upstream sequencer for the `tm1638` serial driver.
- Each frame:
  - Snapshots 8 hex digits, 8 decimal points and 8 LEDs from game logic.
  - Issues 16 single-byte writes to the driver (even addresses hold digit segments, odd addresses hold LEDs).
  - Issues one key read.
- Publishes the key byte, debounced, with per-key press pulses.
- Frames repeat at a fixed refresh period, so game logic never talks to the driver directly.

---
 rtl/tm1638_scan_pkg.sv | 42 ++++
 rtl/tm1638_hex7seg.sv | 17 +
 rtl/tm1638_frame_scanner.sv | 250 +++++++++++++++++++++++++
 tb/tb_tm1638_frame_scanner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_scan_pkg.sv
// ----------------------------------------------------------------------------
// tm1638_scan_pkg
//
// Shared definitions for the TM1638 frame scanner:
//   - state_t            : frame sequencer states
//   - SLOTS / SLOT_W     : number of display write slots and the slot index width
//   - FIRST_DIGIT_ADDR   : address of the first write in a frame
//   - LAST_ADDR          : address of the last write before the key read
//   - SEG7               : hex nibble to 7-segment pattern (bit 0 = a .. bit 6 = g)
//   - digit_nibble()     : selects hex digit k (k = 0 is the leftmost digit)
// ----------------------------------------------------------------------------
package tm1638_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    localparam int SLOTS  = 16;
    localparam int SLOT_W = $clog2(SLOTS);

    localparam logic [SLOT_W-1:0] FIRST_DIGIT_ADDR = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] LAST_ADDR        = SLOT_W'(SLOTS - 1);

    // Active-high segment patterns, indexed by the hex value 0..F.
    localparam logic [6:0] SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Digit 0 lives in the top nibble, digit 7 in the bottom nibble.
    function automatic logic [3:0] digit_nibble(input logic [31:0] digits,
                                                input logic [2:0]  k);
        return digits[(28 - 4 * int'(k)) +: 4];
    endfunction

endpackage

// File: rtl/tm1638_hex7seg.sv
// ----------------------------------------------------------------------------
// tm1638_hex7seg
//
// Purely combinational hex-to-7-segment decoder.
//   nibble : in  4  hex value to display
//   seg    : out 7  segment pattern, bit 0 = a .. bit 6 = g, active-high
// ----------------------------------------------------------------------------
module tm1638_hex7seg
    import tm1638_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7[nibble];

endmodule

// File: rtl/tm1638_frame_scanner.sv
// ----------------------------------------------------------------------------
// tm1638_frame_scanner
//
// Upstream sequencer for the tm1638 serial driver. On every refresh tick it
// snapshots the game-side display state, writes 16 bytes to the driver
// (even addresses = digit segments + decimal point, odd addresses = LED),
// then reads the key byte and publishes it with per-key press pulses.
//
// Parameters:
//   REFRESH_CYCLES : clock cycles between refresh ticks (>= 2)
//
// Ports:
//   CLK_IN      in   1  clock, posedge
//   RST_IN      in   1  asynchronous active-low reset
//   ENABLE      in   1  permits new frames to start
//   DIGITS_IN   in  32  8 hex digits, [31:28] is the leftmost (address 0)
//   DP_IN       in   8  decimal points, bit 7 is the leftmost digit
//   LED_IN      in   8  LEDs, bit 7 -> address 1 .. bit 0 -> address 15
//   TM_READY    in   1  driver idle
//   TM_WRITE    out  1  write request
//   TM_READ     out  1  read request
//   TM_ADDR     out  4  write address
//   TM_DATA_WR  out  8  write data
//   TM_DATA_RD  in   8  key byte from the driver
//   KEYS        out  8  current key state (1 = pressed)
//   KEY_PRESS   out  8  one-cycle pulse per key on a 0->1 transition of KEYS
//   BUSY        out  1  high while a frame is in progress
//   FRAME_DONE  out  1  one-cycle pulse when the key read completes
//
// Build option:
//   TM1638_SCAN_DEBOUNCE_EN : when defined, KEYS only follows the key byte
//                             once two consecutive frames read the same value.
// ----------------------------------------------------------------------------
module tm1638_frame_scanner
    import tm1638_scan_pkg::*;
#(
    parameter int REFRESH_CYCLES = 65536
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic        ENABLE,
    input  logic [31:0] DIGITS_IN,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  LED_IN,
    input  logic        TM_READY,
    output logic        TM_WRITE,
    output logic        TM_READ,
    output logic [3:0]  TM_ADDR,
    output logic [7:0]  TM_DATA_WR,
    input  logic [7:0]  TM_DATA_RD,
    output logic [7:0]  KEYS,
    output logic [7:0]  KEY_PRESS,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    localparam int                CNT_W    = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    // ------------------------------------------------------------------
    // Refresh timebase
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_wrap;
    logic             tick_pending;
    logic             frame_start;

    state_t            state;
    logic [SLOT_W-1:0] slot;

    assign refresh_wrap = (refresh_cnt == CNT_LAST);
    assign frame_start  = (state == IDLE) && tick_pending && ENABLE && TM_READY;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            refresh_cnt  <= '0;
            tick_pending <= 1'b0;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            // A wrap on the same edge as a frame start must not be lost,
            // so the set takes priority over the clear. Repeated wraps
            // simply re-set the same flag, merging into one pending tick.
            if (refresh_wrap) begin
                tick_pending <= 1'b1;
            end else if (frame_start) begin
                tick_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-slot data path
    //
    // TM_ADDR/TM_DATA_WR are loaded on the edge that enters WR_REQ, so the
    // byte is computed for the slot being entered. At frame start the
    // snapshot is being loaded on that same edge, so the live inputs are
    // used instead; they are exactly the values the snapshot captures.
    // ------------------------------------------------------------------
    logic [31:0]       snap_digits;
    logic [7:0]        snap_dp;
    logic [7:0]        snap_led;

    logic [SLOT_W-1:0] next_slot;
    logic [31:0]       src_digits;
    logic [7:0]        src_dp;
    logic [7:0]        src_led;
    logic [2:0]        digit_idx;
    logic [3:0]        hex_nibble;
    logic [6:0]        hex_seg;
    logic [7:0]        next_byte;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        next_slot  = slot + 1'b1;
        src_digits = snap_digits;
        src_dp     = snap_dp;
        src_led    = snap_led;
        if (state == IDLE) begin
            next_slot  = FIRST_DIGIT_ADDR;
            src_digits = DIGITS_IN;
            src_dp     = DP_IN;
            src_led    = LED_IN;
        end
        digit_idx  = next_slot[3:1];
        hex_nibble = digit_nibble(src_digits, digit_idx);
    end

    tm1638_hex7seg u_hex7seg (
        .nibble (hex_nibble),
        .seg    (hex_seg)
    );

    // Even slot 2k: {DP of digit k, segments of digit k}; odd slot: LED k.
    assign next_byte = next_slot[0] ? {7'b0, src_led[3'd7 - digit_idx]}
                                    : {src_dp[3'd7 - digit_idx], hex_seg};

    // ------------------------------------------------------------------
    // Key capture
    // ------------------------------------------------------------------
    logic [7:0] raw;
    logic [7:0] keys_next;

    assign raw = TM_DATA_RD;

`ifdef TM1638_SCAN_DEBOUNCE_EN
    logic [7:0] raw_prev;

    // Only accept a key byte that matches the previous frame's read.
    assign keys_next = (raw == raw_prev) ? raw : KEYS;
`else
    assign keys_next = raw;
`endif

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    // NOTE: the snapshot and key registers are reset explicitly; they are
    // visible on outputs and must come up at a known value.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state       <= IDLE;
            slot        <= FIRST_DIGIT_ADDR;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_led    <= '0;
            TM_WRITE    <= 1'b0;
            TM_READ     <= 1'b0;
            TM_ADDR     <= '0;
            TM_DATA_WR  <= '0;
            KEYS        <= '0;
            KEY_PRESS   <= '0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
`ifdef TM1638_SCAN_DEBOUNCE_EN
            raw_prev    <= '0;
`endif
        end else begin
            // Single-cycle pulses.
            FRAME_DONE <= 1'b0;
            KEY_PRESS  <= '0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= WR_REQ;
                        slot        <= FIRST_DIGIT_ADDR;
                        snap_digits <= DIGITS_IN;
                        snap_dp     <= DP_IN;
                        snap_led    <= LED_IN;
                        TM_ADDR     <= next_slot;
                        TM_DATA_WR  <= next_byte;
                        TM_WRITE    <= 1'b1;
                        BUSY        <= 1'b1;
                    end
                end

                // Hold the request until the driver shows it has taken it.
                WR_REQ: begin
                    if (!TM_READY) begin
                        TM_WRITE <= 1'b0;
                        state    <= WR_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (TM_READY) begin
                        if (slot == LAST_ADDR) begin
                            TM_READ <= 1'b1;
                            state   <= RD_REQ;
                        end else begin
                            slot       <= next_slot;
                            TM_ADDR    <= next_slot;
                            TM_DATA_WR <= next_byte;
                            TM_WRITE   <= 1'b1;
                            state      <= WR_REQ;
                        end
                    end
                end

                RD_REQ: begin
                    if (!TM_READY) begin
                        TM_READ <= 1'b0;
                        state   <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (TM_READY) begin
                        KEYS       <= keys_next;
                        KEY_PRESS  <= keys_next & ~KEYS;
                        FRAME_DONE <= 1'b1;
                        BUSY       <= 1'b0;
                        state      <= IDLE;
`ifdef TM1638_SCAN_DEBOUNCE_EN
                        raw_prev   <= raw;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_frame_scanner.sv
// ----------------------------------------------------------------------------
// tb_tm1638_frame_scanner
//
// Directed bench for tm1638_frame_scanner with a behavioural driver model
// that drops READY for a fixed number of cycles per accepted request.
// Honours TM1638_SCAN_DEBOUNCE_EN for the key-state expectations.
// ----------------------------------------------------------------------------
module tb_tm1638_frame_scanner;

    localparam int REFRESH   = 64;
    localparam int DRV_DELAY = 20;
    localparam int FRAME_BUDGET = 1500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  led = '0;
    logic        ready = 1'b1;
    logic        tm_write;
    logic        tm_read;
    logic [3:0]  tm_addr;
    logic [7:0]  tm_data_wr;
    logic [7:0]  tm_data_rd = '0;
    logic [7:0]  keys;
    logic [7:0]  key_press;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Driver-side log of accepted requests.
    logic [3:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         rd_count   = 0;
    int         proto_viol = 0;

    // Hand-computed frame contents.
    // 0123ABCF, DP=01, LED=80
    logic [7:0] exp_a [16] = '{8'h3F, 8'h01, 8'h06, 8'h00, 8'h5B, 8'h00, 8'h4F, 8'h00,
                               8'h77, 8'h00, 8'h7C, 8'h00, 8'h39, 8'h00, 8'hF1, 8'h00};
    // FFFFFFFF, DP=01, LED=80
    logic [7:0] exp_f [16] = '{8'h71, 8'h01, 8'h71, 8'h00, 8'h71, 8'h00, 8'h71, 8'h00,
                               8'h71, 8'h00, 8'h71, 8'h00, 8'h71, 8'h00, 8'hF1, 8'h00};

`ifdef TM1638_SCAN_DEBOUNCE_EN
    localparam logic [7:0] K4 = 8'h00, P4 = 8'h00, K5 = 8'h04, P5 = 8'h04;
    localparam logic [7:0] K6 = 8'h04, K7 = 8'h00;
`else
    localparam logic [7:0] K4 = 8'h04, P4 = 8'h04, K5 = 8'h04, P5 = 8'h00;
    localparam logic [7:0] K6 = 8'h00, K7 = 8'h00;
`endif

    tm1638_frame_scanner #(
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .CLK_IN     (clk),
        .RST_IN     (rst_n),
        .ENABLE     (enable),
        .DIGITS_IN  (digits),
        .DP_IN      (dp),
        .LED_IN     (led),
        .TM_READY   (ready),
        .TM_WRITE   (tm_write),
        .TM_READ    (tm_read),
        .TM_ADDR    (tm_addr),
        .TM_DATA_WR (tm_data_wr),
        .TM_DATA_RD (tm_data_rd),
        .KEYS       (keys),
        .KEY_PRESS  (key_press),
        .BUSY       (busy),
        .FRAME_DONE (frame_done)
    );

    always #5 clk = ~clk;

    // Driver model: accept a request seen at a falling edge, then stay busy.
    initial begin
        forever begin
            @(negedge clk);
            if (ready && (tm_write || tm_read)) begin
                if (tm_write) begin
                    wr_addr_q.push_back(tm_addr);
                    wr_data_q.push_back(tm_data_wr);
                end else begin
                    rd_count++;
                end
                ready = 1'b0;
                repeat (DRV_DELAY) @(negedge clk);
                ready = 1'b1;
            end
        end
    end

    // Request-rule monitor: sampled just after each rising edge, where
    // READY still holds the value the DUT saw on that edge.
    initial begin
        logic prev_w = 1'b0;
        logic prev_r = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tm_write && tm_read) proto_viol++;
            if (((tm_write && !prev_w) || (tm_read && !prev_r)) && !ready) proto_viol++;
            prev_w = tm_write;
            prev_r = tm_read;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_word();
        return {tm_write, tm_read, tm_addr, tm_data_wr, keys, key_press, busy, frame_done};
    endfunction

    task automatic wait_frame_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < FRAME_BUDGET && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int target);
        logic seen = 1'b0;
        for (int i = 0; i < FRAME_BUDGET && !seen; i++) begin
            @(negedge clk);
            if (wr_addr_q.size() >= target) seen = 1'b1;
        end
        check({tag, "_writes_reached"}, 32'(seen), 32'd1);
    endtask

    task automatic count_to_first_write(input string tag, input int exp_cycles);
        int n = 0;
        while (!tm_write && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] exp [16]);
        check({tag, "_write_count"}, 32'(wr_addr_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wr_addr_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[base + i]), 32'(i));
                check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[base + i]), 32'(exp[i]));
            end
        end
    endtask

    initial begin
        int   base;
        logic busy_seen;

        // ---------------- reset state ----------------
        rst_n      = 1'b0;
        enable     = 1'b1;
        digits     = 32'h0123ABCF;
        dp         = 8'h01;
        led        = 8'h80;
        tm_data_rd = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_word(), 32'd0);

        // ---------------- 1: write frame ----------------
        rst_n = 1'b1;
        count_to_first_write("first_req_latency", REFRESH + 1);
        check("busy_in_frame", 32'(busy), 32'd1);
        wait_frame_done("f1");
        check("f1_busy_low", 32'(busy), 32'd0);
        check("f1_keys", 32'(keys), 32'd0);
        check_frame("f1", 0, exp_a);
        check("f1_reads", 32'(rd_count), 32'd1);

        // ---------------- 2: snapshot coherence ----------------
        base = wr_addr_q.size();
        wait_writes("f2", base + 4);
        digits = 32'hFFFFFFFF;
        wait_frame_done("f2");
        check_frame("f2", base, exp_a);

        base = wr_addr_q.size();
        wait_frame_done("f3");
        check_frame("f3", base, exp_f);

        // ---------------- 3: key press ----------------
        tm_data_rd = 8'h04;
        wait_frame_done("f4");
        check("f4_keys", 32'(keys), 32'(K4));
        check("f4_press", 32'(key_press), 32'(P4));
        wait_frame_done("f5");
        check("f5_keys", 32'(keys), 32'(K5));
        check("f5_press", 32'(key_press), 32'(P5));
        tm_data_rd = 8'h00;
        @(negedge clk);
        check("press_one_cycle", 32'(key_press), 32'd0);
        // Frames overrun the refresh period, so the next one starts at once.
        check("overrun_back_to_back", 32'(tm_write), 32'd1);

        // ---------------- 4: key release ----------------
        wait_frame_done("f6");
        check("f6_keys", 32'(keys), 32'(K6));
        check("f6_press", 32'(key_press), 32'd0);
        wait_frame_done("f7");
        check("f7_keys", 32'(keys), 32'(K7));
        check("f7_press", 32'(key_press), 32'd0);

        // ---------------- 5: ENABLE drop mid-frame ----------------
        base = wr_addr_q.size();
        wait_writes("f8", base + 8);
        enable = 1'b0;
        wait_frame_done("f8");
        check("f8_write_count", 32'(wr_addr_q.size() - base), 32'd16);
        check("f8_reads", 32'(rd_count), 32'd8);
        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (busy || tm_write || tm_read) busy_seen = 1'b1;
        end
        check("idle_after_disable", 32'(busy_seen), 32'd0);

        // ---------------- 6: reset mid-operation ----------------
        enable = 1'b1;
        base = wr_addr_q.size();
        wait_writes("f9", base + 3);
        @(negedge clk);
        @(negedge clk);
        check("wr_wait_before_reset", {26'd0, busy, tm_write, tm_addr}, 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_word(), 32'd0);
        busy_seen = 1'b0;
        for (int i = 0; i < 50 && !busy_seen; i++) begin
            @(negedge clk);
            if (ready) busy_seen = 1'b1;
        end
        check("driver_idle_in_reset", 32'(busy_seen), 32'd1);
        base = wr_addr_q.size();
        rst_n = 1'b1;
        count_to_first_write("post_reset_latency", REFRESH + 1);
        wait_frame_done("f10");
        check_frame("f10", base, exp_f);

        check("protocol_violations", 32'(proto_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
